// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: orders p_reset_n -> clk_enb -> s_reset_n after e_reset_n release,
// runs soft-reboot sequences on request and gates the RISC-V core reset.
module reset_seq_ctrl #(
  parameter int unsigned P_DLY  = 16,
  parameter int unsigned C_DLY  = 8,
  parameter int unsigned S_DLY  = 8,
  parameter int unsigned SR_DLY = 32
) (
  input  logic       clk,
  input  logic       e_reset_n,
  input  logic       soft_reboot_req,
  input  logic       cfg_riscv_rst_rel,
  input  logic       sw_riscv_rst_rel,
  output logic       p_reset_n,
  output logic       clk_enb,
  output logic       s_reset_n,
  output logic       cpu_rst_n,
  output logic [7:0] reboot_cnt,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    PWR_RST  = 3'd0,
    CLK_WAIT = 3'd1,
    SYS_WAIT = 3'd2,
    ACTIVE   = 3'd3,
    SOFT_RST = 3'd4
  } state_t;

  localparam logic [7:0] P_LD  = 8'(P_DLY - 1);
  localparam logic [7:0] C_LD  = 8'(C_DLY - 1);
  localparam logic [7:0] S_LD  = 8'(S_DLY - 1);
  localparam logic [7:0] SR_LD = 8'(SR_DLY - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] rst_sync;
  logic       rst_sync_n;
  logic       req_p0;
  logic       req_p1;
  logic       req_hist;
  logic       req_rise;

  assign rst_sync_n = rst_sync[1];
  assign seq_state  = state;

  // Reset synchronizer: asserts asynchronously, releases on the 2nd edge.
  always_ff @(posedge clk or negedge e_reset_n) begin
    if (!e_reset_n) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end

  // Request synchronizer stages p0 -> p1
  always_ff @(posedge clk or negedge e_reset_n) begin
    if (!e_reset_n) begin
      req_p0 <= 1'b0;
      req_p1 <= 1'b0;
    end else begin
      req_p0 <= soft_reboot_req;
      req_p1 <= req_p0;
    end
  end

  // History only advances in ACTIVE, so edges seen elsewhere are discarded and
  // a request already high at boot still fires once on the first ACTIVE cycle.
  assign req_rise = req_p1 & ~req_hist;

  always_ff @(posedge clk or negedge e_reset_n) begin
    if (!e_reset_n) begin
      state      <= PWR_RST;
      cnt        <= P_LD;
      p_reset_n  <= 1'b0;
      clk_enb    <= 1'b0;
      s_reset_n  <= 1'b0;
      cpu_rst_n  <= 1'b0;
      reboot_cnt <= 8'd0;
      req_hist   <= 1'b0;
    end else if (!rst_sync_n) begin
      state      <= PWR_RST;
      cnt        <= P_LD;
      p_reset_n  <= 1'b0;
      clk_enb    <= 1'b0;
      s_reset_n  <= 1'b0;
      cpu_rst_n  <= 1'b0;
      reboot_cnt <= 8'd0;
      req_hist   <= 1'b0;
    end else begin
      cpu_rst_n <= 1'b0;
      case (state)
        PWR_RST: begin
          if (cnt == 8'd0) begin
            state     <= CLK_WAIT;
            cnt       <= C_LD;
            p_reset_n <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        CLK_WAIT: begin
          if (cnt == 8'd0) begin
            state   <= SYS_WAIT;
            cnt     <= S_LD;
            clk_enb <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SYS_WAIT: begin
          if (cnt == 8'd0) begin
            state     <= ACTIVE;
            cnt       <= 8'd0;
            s_reset_n <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ACTIVE: begin
          req_hist <= req_p1;
          if (req_rise) begin
            state     <= SOFT_RST;
            cnt       <= SR_LD;
            s_reset_n <= 1'b0;
            clk_enb   <= 1'b0;
          end else begin
            cpu_rst_n <= s_reset_n & (cfg_riscv_rst_rel | sw_riscv_rst_rel);
          end
        end
        SOFT_RST: begin
          if (cnt == 8'd0) begin
            state      <= CLK_WAIT;
            cnt        <= C_LD;
            reboot_cnt <= sat_inc(reboot_cnt);
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state      <= PWR_RST;
          cnt        <= P_LD;
          p_reset_n  <= 1'b0;
          clk_enb    <= 1'b0;
          s_reset_n  <= 1'b0;
          reboot_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule
